// File: rtl/inst_rom_resp_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : inst_rom_resp_if                                          |
// | Brief  : Fetch/loader bus between the PC stage and the instruction |
// |          memory responder.                                         |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
interface inst_rom_resp_if #(
  parameter int ADDR_W = 10
);
  logic              ce_i;
  logic [31:0]       pc_i;
  logic              flush_i;
  logic              ld_we_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [31:0]       ld_data_i;
  logic [31:0]       inst_o;
  logic              inst_valid_o;
  logic              range_err_o;
  logic              stallreq_o;

  // Fetch side / loader side: drives requests and write data
  modport master (
    output ce_i, pc_i, flush_i, ld_we_i, ld_addr_i, ld_data_i,
    input  inst_o, inst_valid_o, range_err_o, stallreq_o
  );

  // Memory responder side
  modport slave (
    input  ce_i, pc_i, flush_i, ld_we_i, ld_addr_i, ld_data_i,
    output inst_o, inst_valid_o, range_err_o, stallreq_o
  );
endinterface
`default_nettype wire

// File: rtl/inst_rom_resp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : inst_rom_resp                                             |
// | Brief  : Word-addressed instruction store with programmable wait   |
// |          states, stall request toward the PC, flush abort and a    |
// |          loader write port.                                        |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module inst_rom_resp #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  inst_rom_resp_if.slave    bus
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic       NO_WAIT  = (WAIT_CYC == 0);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        rerr_q, rerr_d;

  logic              ready;
  logic [31:0]       rd_addr;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_oor;
  logic [31:0]       rd_word;
  logic              unused_lsb;

  // Once waiting, the latched address is used so PC moves under stall are harmless
  assign ready      = NO_WAIT | (state_q == BUSY && cnt_q == 4'd0);
  assign rd_addr    = (state_q == BUSY) ? pc_q : bus.pc_i;
  assign rd_idx     = rd_addr[ADDR_W+1:2];
  assign rd_oor     = |rd_addr[31:ADDR_W+2];
  assign rd_word    = mem[rd_idx];
  assign unused_lsb = ^rd_addr[1:0];

  // Stall is dropped during a flush so the PC can take the branch target
  assign bus.stallreq_o   = bus.ce_i & ~ready & ~bus.flush_i;
  assign bus.inst_o       = inst_q;
  assign bus.inst_valid_o = valid_q;
  assign bus.range_err_o  = rerr_q;

  // Loader write; the fetch path samples the old word on a same-edge collision
  always_ff @(posedge clk) begin
    if (bus.ld_we_i) begin
      mem[bus.ld_addr_i] <= bus.ld_data_i;
    end
  end

  // Fetch state and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pc_q    <= 32'd0;
      inst_q  <= 32'd0;
      valid_q <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      rerr_q  <= rerr_d;
    end
  end

  // Next-state: abort, complete, start a wait, or count down
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    rerr_d  = rerr_q;
    if (bus.flush_i || !bus.ce_i) begin
      state_d = IDLE;
      inst_d  = 32'd0;
      valid_d = 1'b0;
      rerr_d  = 1'b0;
    end else if (ready) begin
      state_d = IDLE;
      inst_d  = rd_oor ? 32'd0 : rd_word;
      valid_d = 1'b1;
      rerr_d  = rd_oor;
    end else if (state_q == IDLE) begin
      state_d = BUSY;
      pc_d    = bus.pc_i;
      cnt_d   = CNT_LOAD;
      valid_d = 1'b0;
      rerr_d  = 1'b0;
    end else begin
      cnt_d   = cnt_q - 4'd1;
      valid_d = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_resp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_inst_rom_resp                                          |
// | Brief  : Directed self-checking bench, one responder per wait      |
// |          setting (0, 2, 3, 4).                                     |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_inst_rom_resp;

  logic clk;
  logic rst;
  logic rst4;
  int   checks;
  int   errors;

  inst_rom_resp_if #(.ADDR_W(10)) if0 ();
  inst_rom_resp_if #(.ADDR_W(10)) if2 ();
  inst_rom_resp_if #(.ADDR_W(10)) if3 ();
  inst_rom_resp_if #(.ADDR_W(10)) if4 ();

  inst_rom_resp #(.ADDR_W(10), .WAIT_CYC(0)) dut0 (.clk(clk), .rst(rst),  .bus(if0));
  inst_rom_resp #(.ADDR_W(10), .WAIT_CYC(2)) dut2 (.clk(clk), .rst(rst),  .bus(if2));
  inst_rom_resp #(.ADDR_W(10), .WAIT_CYC(3)) dut3 (.clk(clk), .rst(rst),  .bus(if3));
  inst_rom_resp #(.ADDR_W(10), .WAIT_CYC(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4));

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Same loader write to every responder, one cycle per word
  task automatic load(input logic [9:0] a, input logic [31:0] d);
    if0.ld_we_i = 1'b1; if0.ld_addr_i = a; if0.ld_data_i = d;
    if2.ld_we_i = 1'b1; if2.ld_addr_i = a; if2.ld_data_i = d;
    if3.ld_we_i = 1'b1; if3.ld_addr_i = a; if3.ld_data_i = d;
    if4.ld_we_i = 1'b1; if4.ld_addr_i = a; if4.ld_data_i = d;
    @(negedge clk);
    if0.ld_we_i = 1'b0;
    if2.ld_we_i = 1'b0;
    if3.ld_we_i = 1'b0;
    if4.ld_we_i = 1'b0;
  endtask

  // Directed sequence; inputs change and outputs are sampled just after falling edges
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rst4 = 1'b1;
    if0.ce_i = 0; if0.pc_i = 0; if0.flush_i = 0; if0.ld_we_i = 0; if0.ld_addr_i = 0; if0.ld_data_i = 0;
    if2.ce_i = 0; if2.pc_i = 0; if2.flush_i = 0; if2.ld_we_i = 0; if2.ld_addr_i = 0; if2.ld_data_i = 0;
    if3.ce_i = 0; if3.pc_i = 0; if3.flush_i = 0; if3.ld_we_i = 0; if3.ld_addr_i = 0; if3.ld_data_i = 0;
    if4.ce_i = 0; if4.pc_i = 0; if4.flush_i = 0; if4.ld_we_i = 0; if4.ld_addr_i = 0; if4.ld_data_i = 0;
    #1;
    chk("rst_inst0",  if0.inst_o, 32'd0);
    chk("rst_valid0", {31'd0, if0.inst_valid_o}, 32'd0);
    chk("rst_rerr0",  {31'd0, if0.range_err_o}, 32'd0);
    chk("rst_stall2", {31'd0, if2.stallreq_o}, 32'd0);
    chk("rst_valid2", {31'd0, if2.inst_valid_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rst4 = 1'b0;

    load(10'd0, 32'h11111111);
    load(10'd1, 32'h22222222);
    load(10'd2, 32'h33333333);
    load(10'd3, 32'h44444444);
    load(10'd5, 32'hAAAA0000);
    load(10'd16, 32'h1600CAFE);

    // Zero wait states: one fetch per cycle, never a stall
    if0.ce_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if0.pc_i = 32'(4 * i);
      #1;
      chk("w0_stall", {31'd0, if0.stallreq_o}, 32'd0);
      @(negedge clk);
      #1;
      chk("w0_inst",  if0.inst_o, 32'h11111111 * 32'(i + 1));
      chk("w0_valid", {31'd0, if0.inst_valid_o}, 32'd1);
    end

    // Out-of-range fetch right after a real one
    if0.pc_i = 32'h00001000;
    @(negedge clk);
    #1;
    chk("oor_inst",  if0.inst_o, 32'd0);
    chk("oor_valid", {31'd0, if0.inst_valid_o}, 32'd1);
    chk("oor_rerr",  {31'd0, if0.range_err_o}, 32'd1);
    if0.ce_i = 1'b0;
    @(negedge clk);
    #1;
    chk("oor_valid_off", {31'd0, if0.inst_valid_o}, 32'd0);
    chk("oor_rerr_off",  {31'd0, if0.range_err_o}, 32'd0);

    // Read/write collision on word 5
    if0.ce_i = 1'b1;
    if0.pc_i = 32'h14;
    if0.ld_we_i = 1'b1; if0.ld_addr_i = 10'd5; if0.ld_data_i = 32'hBBBB0000;
    @(negedge clk);
    #1;
    if0.ld_we_i = 1'b0;
    chk("col_old", if0.inst_o, 32'hAAAA0000);
    @(negedge clk);
    #1;
    chk("col_new", if0.inst_o, 32'hBBBB0000);
    if0.ce_i = 1'b0;

    // Two wait states, PC disturbed under stall, then back-to-back fetch
    if2.ce_i = 1'b1;
    if2.pc_i = 32'h8;
    #1;
    chk("w2_stall_t0", {31'd0, if2.stallreq_o}, 32'd1);
    @(negedge clk);
    if2.pc_i = 32'hFC;
    #1;
    chk("w2_stall_t1", {31'd0, if2.stallreq_o}, 32'd1);
    chk("w2_valid_t1", {31'd0, if2.inst_valid_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("w2_stall_t2", {31'd0, if2.stallreq_o}, 32'd0);
    chk("w2_valid_t2", {31'd0, if2.inst_valid_o}, 32'd0);
    @(negedge clk);
    if2.pc_i = 32'hC;
    #1;
    chk("w2_valid_t3", {31'd0, if2.inst_valid_o}, 32'd1);
    chk("w2_inst_t3",  if2.inst_o, 32'h33333333);
    chk("w2_stall_t3", {31'd0, if2.stallreq_o}, 32'd1);
    @(negedge clk);
    #1;
    chk("w2_valid_t4", {31'd0, if2.inst_valid_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("w2_valid_t5", {31'd0, if2.inst_valid_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("w2_valid_t6", {31'd0, if2.inst_valid_o}, 32'd1);
    chk("w2_inst_t6",  if2.inst_o, 32'h44444444);
    if2.ce_i = 1'b0;

    // Three wait states, flush in the second busy cycle
    if3.ce_i = 1'b1;
    if3.pc_i = 32'h4;
    @(negedge clk);
    #1;
    chk("fl_valid_b1", {31'd0, if3.inst_valid_o}, 32'd0);
    @(negedge clk);
    if3.flush_i = 1'b1;
    if3.pc_i = 32'h40;
    #1;
    chk("fl_stall", {31'd0, if3.stallreq_o}, 32'd0);
    @(negedge clk);
    if3.flush_i = 1'b0;
    #1;
    chk("fl_valid_after", {31'd0, if3.inst_valid_o}, 32'd0);
    chk("fl_stall_new",   {31'd0, if3.stallreq_o}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("fl_valid_wait", {31'd0, if3.inst_valid_o}, 32'd0);
    end
    @(negedge clk);
    #1;
    chk("fl_valid_done", {31'd0, if3.inst_valid_o}, 32'd1);
    chk("fl_inst_done",  if3.inst_o, 32'h1600CAFE);
    chk("fl_rerr_done",  {31'd0, if3.range_err_o}, 32'd0);
    if3.ce_i = 1'b0;

    // Four wait states: complete one fetch, then reset asynchronously mid-fetch
    if4.ce_i = 1'b1;
    if4.pc_i = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
    end
    @(negedge clk);
    if4.pc_i = 32'h4;
    #1;
    chk("ar_first_inst", if4.inst_o, 32'h11111111);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ar_stall_busy", {31'd0, if4.stallreq_o}, 32'd1);
    #2;
    rst4 = 1'b1;
    if4.ce_i = 1'b0;
    #1;
    chk("ar_inst",  if4.inst_o, 32'd0);
    chk("ar_valid", {31'd0, if4.inst_valid_o}, 32'd0);
    chk("ar_rerr",  {31'd0, if4.range_err_o}, 32'd0);
    chk("ar_stall", {31'd0, if4.stallreq_o}, 32'd0);
    @(negedge clk);
    rst4 = 1'b0;
    if4.ce_i = 1'b1;
    if4.pc_i = 32'h4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("ar_refetch_wait", {31'd0, if4.inst_valid_o}, 32'd0);
    end
    @(negedge clk);
    #1;
    chk("ar_refetch_valid", {31'd0, if4.inst_valid_o}, 32'd1);
    chk("ar_refetch_inst",  if4.inst_o, 32'h22222222);
    if4.ce_i = 1'b0;

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
